// File: rtl/pzcorebus_request_m_to_1_switch.sv
// Merges MASTERS upstream pzcorebus request ports onto one downstream port: round-robin command
// arbitration with grant lock, port index stamped into mid, write data ordered by a queue of port indices.
module pzcorebus_request_m_to_1_switch #(
    parameter int MASTERS      = 2,
    parameter int ID_W         = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 8,
    parameter int SELECT_WIDTH = $clog2(MASTERS),
    parameter int SELECT_LSB   = ID_W - SELECT_WIDTH,
    parameter int WRITE_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    output logic [MASTERS-1:0]            o_grant,
    output logic [$clog2(WRITE_DEPTH+1)-1:0] o_write_pending,
    output logic [MASTERS-1:0]            slave_scmd_accept,
    input  logic [MASTERS-1:0]            slave_mcmd_valid,
    input  logic [MASTERS*3-1:0]          slave_mcmd,
    input  logic [MASTERS*ID_W-1:0]       slave_mid,
    input  logic [MASTERS*ADDR_W-1:0]     slave_maddr,
    input  logic [MASTERS*LEN_W-1:0]      slave_mlength,
    output logic [MASTERS-1:0]            slave_sdata_accept,
    input  logic [MASTERS-1:0]            slave_mdata_valid,
    input  logic [MASTERS*DATA_W-1:0]     slave_mdata,
    input  logic [MASTERS-1:0]            slave_mdata_last,
    input  logic                          master_scmd_accept,
    output logic                          master_mcmd_valid,
    output logic [2:0]                    master_mcmd,
    output logic [ID_W-1:0]               master_mid,
    output logic [ADDR_W-1:0]             master_maddr,
    output logic [LEN_W-1:0]              master_mlength,
    input  logic                          master_sdata_accept,
    output logic                          master_mdata_valid,
    output logic [DATA_W-1:0]             master_mdata,
    output logic                          master_mdata_last
);
    localparam int PTR_W = (WRITE_DEPTH > 1) ? $clog2(WRITE_DEPTH) : 1;
    localparam int CNT_W = $clog2(WRITE_DEPTH + 1);
    localparam logic [2:0] CMD_WRITE    = 3'b101;
    localparam logic [2:0] CMD_WRITE_NP = 3'b111;

    function automatic logic carries_data(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_NP);
    endfunction

    function automatic logic [SELECT_WIDTH-1:0] next_index(input logic [SELECT_WIDTH-1:0] idx);
        return (idx == SELECT_WIDTH'(MASTERS - 1)) ? '0 : idx + SELECT_WIDTH'(1);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(WRITE_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic [SELECT_WIDTH-1:0] rr;
    logic                    lock_valid;
    logic [SELECT_WIDTH-1:0] lock_index;
    logic [SELECT_WIDTH-1:0] gnt_idx;
    logic [SELECT_WIDTH:0]   sum;
    logic [MASTERS-1:0]      eligible;
    logic [MASTERS-1:0]      rot;
    logic                    found;
    logic                    gnt_any;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [SELECT_WIDTH-1:0] order_q [WRITE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [SELECT_WIDTH-1:0] head;

    assign full            = (count == CNT_W'(WRITE_DEPTH));
    assign empty           = (count == '0);
    assign head            = order_q[rd_ptr];
    assign o_write_pending = count;

    // Writes are hidden from arbitration while the order queue cannot take another entry.
    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            eligible[i] = slave_mcmd_valid[i] && !(full && carries_data(slave_mcmd[i*3 +: 3]));
        end
        rot   = MASTERS'({eligible, eligible} >> rr);
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr} + (SELECT_WIDTH+1)'(i);
            end
        end
        if (sum >= (SELECT_WIDTH+1)'(MASTERS)) begin
            sum = sum - (SELECT_WIDTH+1)'(MASTERS);
        end
        gnt_idx = lock_valid ? lock_index : sum[SELECT_WIDTH-1:0];
        gnt_any = lock_valid || found;
        for (int i = 0; i < MASTERS; i++) begin
            o_grant[i]           = gnt_any && (gnt_idx == SELECT_WIDTH'(i)) && slave_mcmd_valid[i];
            slave_scmd_accept[i] = o_grant[i] && master_scmd_accept;
        end
    end

    always_comb begin
        master_mcmd_valid = |o_grant;
        master_mcmd       = slave_mcmd[2:0];
        master_mid        = slave_mid[ID_W-1:0];
        master_maddr      = slave_maddr[ADDR_W-1:0];
        master_mlength    = slave_mlength[LEN_W-1:0];
        for (int i = 0; i < MASTERS; i++) begin
            if (gnt_idx == SELECT_WIDTH'(i)) begin
                master_mcmd    = slave_mcmd[i*3 +: 3];
                master_mid     = slave_mid[i*ID_W +: ID_W];
                master_maddr   = slave_maddr[i*ADDR_W +: ADDR_W];
                master_mlength = slave_mlength[i*LEN_W +: LEN_W];
            end
        end
        master_mid[SELECT_LSB +: SELECT_WIDTH] = gnt_idx;
    end

    // Data source follows the oldest accepted write whose burst is not yet complete.
    always_comb begin
        master_mdata_valid = 1'b0;
        master_mdata       = slave_mdata[DATA_W-1:0];
        master_mdata_last  = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (head == SELECT_WIDTH'(i)) begin
                master_mdata_valid = !empty && slave_mdata_valid[i];
                master_mdata       = slave_mdata[i*DATA_W +: DATA_W];
                master_mdata_last  = slave_mdata_last[i];
            end
            slave_sdata_accept[i] = !empty && (head == SELECT_WIDTH'(i)) && master_sdata_accept;
        end
    end

    assign push = master_mcmd_valid && master_scmd_accept && carries_data(master_mcmd);
    assign pop  = master_mdata_valid && master_sdata_accept && master_mdata_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr         <= '0;
            lock_valid <= 1'b0;
            lock_index <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (master_mcmd_valid) begin
                if (master_scmd_accept) begin
                    lock_valid <= 1'b0;
                    rr         <= next_index(gnt_idx);
                end else begin
                    lock_valid <= 1'b1;
                    lock_index <= gnt_idx;
                end
            end
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) order_q[wr_ptr] <= gnt_idx;
    end

endmodule

// File: tb/tb_pzcorebus_request_m_to_1_switch.sv
// Scoreboard bench for pzcorebus_request_m_to_1_switch: 3 ports, 2-entry write-order queue,
// queue-driven upstream ports and expected command/data queues checked at the downstream port.
module tb_pzcorebus_request_m_to_1_switch;
    localparam int M      = 3;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;
    localparam int WD     = 2;
    localparam logic [2:0] CMD_READ  = 3'b100;
    localparam logic [2:0] CMD_WRITE = 3'b101;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic [M-1:0]          o_grant;
    logic [1:0]            o_write_pending;
    logic [M-1:0]          slave_scmd_accept;
    logic [M-1:0]          slave_mcmd_valid = '0;
    logic [M*3-1:0]        slave_mcmd = '0;
    logic [M*ID_W-1:0]     slave_mid = '0;
    logic [M*ADDR_W-1:0]   slave_maddr = '0;
    logic [M*LEN_W-1:0]    slave_mlength = '0;
    logic [M-1:0]          slave_sdata_accept;
    logic [M-1:0]          slave_mdata_valid = '0;
    logic [M*DATA_W-1:0]   slave_mdata = '0;
    logic [M-1:0]          slave_mdata_last = '0;
    logic                  master_scmd_accept = 1'b1;
    logic                  master_mcmd_valid;
    logic [2:0]            master_mcmd;
    logic [ID_W-1:0]       master_mid;
    logic [ADDR_W-1:0]     master_maddr;
    logic [LEN_W-1:0]      master_mlength;
    logic                  master_sdata_accept = 1'b1;
    logic                  master_mdata_valid;
    logic [DATA_W-1:0]     master_mdata;
    logic                  master_mdata_last;

    pzcorebus_request_m_to_1_switch #(
        .MASTERS(M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .WRITE_DEPTH(WD)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_grant(o_grant), .o_write_pending(o_write_pending),
        .slave_scmd_accept(slave_scmd_accept), .slave_mcmd_valid(slave_mcmd_valid),
        .slave_mcmd(slave_mcmd), .slave_mid(slave_mid), .slave_maddr(slave_maddr),
        .slave_mlength(slave_mlength), .slave_sdata_accept(slave_sdata_accept),
        .slave_mdata_valid(slave_mdata_valid), .slave_mdata(slave_mdata),
        .slave_mdata_last(slave_mdata_last), .master_scmd_accept(master_scmd_accept),
        .master_mcmd_valid(master_mcmd_valid), .master_mcmd(master_mcmd),
        .master_mid(master_mid), .master_maddr(master_maddr), .master_mlength(master_mlength),
        .master_sdata_accept(master_sdata_accept), .master_mdata_valid(master_mdata_valid),
        .master_mdata(master_mdata), .master_mdata_last(master_mdata_last)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  mid;
        logic [3:0]  len;
        logic [2:0]  acc;
    } cmd_t;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    cmd_t   port_cmd_q [M][$];
    beat_t  port_dat_q [M][$];
    bit     hold [M];
    cmd_t   exp_cmd_q [$];
    beat_t  exp_dat_q [$];
    logic [M-1:0] cmd_hs = '0;
    logic [M-1:0] dat_hs = '0;
    int     beats_seen = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_write(input int p, input logic [15:0] addr, input int len);
        beat_t b;
        port_cmd_q[p].push_back({CMD_WRITE, addr, {2'b11, addr[5:0]}, 4'(len), 3'b000});
        for (int k = 0; k < len; k++) begin
            b.data = addr + 16'(k);
            b.last = (k == len - 1);
            port_dat_q[p].push_back(b);
        end
    endtask

    task automatic send_read(input int p, input logic [15:0] addr);
        port_cmd_q[p].push_back({CMD_READ, addr, {2'b11, addr[5:0]}, 4'd1, 3'b000});
    endtask

    task automatic expect_write(input int p, input logic [15:0] addr, input int len);
        beat_t b;
        exp_cmd_q.push_back({CMD_WRITE, addr, {2'(p), addr[5:0]}, 4'(len), 3'(1 << p)});
        for (int k = 0; k < len; k++) begin
            b.data = addr + 16'(k);
            b.last = (k == len - 1);
            exp_dat_q.push_back(b);
        end
    endtask

    task automatic expect_read(input int p, input logic [15:0] addr);
        exp_cmd_q.push_back({CMD_READ, addr, {2'(p), addr[5:0]}, 4'd1, 3'(1 << p)});
    endtask

    task automatic drive();
        cmd_t  c;
        beat_t b;
        for (int p = 0; p < M; p++) begin
            slave_mcmd_valid[p] = 1'b0;
            if (port_cmd_q[p].size() > 0) begin
                c = port_cmd_q[p][0];
                slave_mcmd_valid[p]            = 1'b1;
                slave_mcmd[p*3 +: 3]           = c.cmd;
                slave_maddr[p*ADDR_W +: ADDR_W] = c.addr;
                slave_mid[p*ID_W +: ID_W]      = c.mid;
                slave_mlength[p*LEN_W +: LEN_W] = c.len;
            end
            slave_mdata_valid[p] = 1'b0;
            slave_mdata_last[p]  = 1'b0;
            if (!hold[p] && port_dat_q[p].size() > 0) begin
                b = port_dat_q[p][0];
                slave_mdata_valid[p]            = 1'b1;
                slave_mdata[p*DATA_W +: DATA_W] = b.data;
                slave_mdata_last[p]             = b.last;
            end
        end
    endtask

    // Present inputs, then observe handshakes half a cycle later.
    task automatic settle();
        cmd_t  e;
        beat_t d;
        drive();
        @(negedge i_clk);
        cmd_hs = slave_mcmd_valid & slave_scmd_accept;
        dat_hs = slave_mdata_valid & slave_sdata_accept;
        if (master_mcmd_valid && master_scmd_accept) begin
            if (exp_cmd_q.size() == 0) begin
                check_val("cmd_unexpected", 32'(master_maddr), 32'hffff_ffff);
            end else begin
                e = exp_cmd_q.pop_front();
                check_val("cmd_type", 32'(master_mcmd), 32'(e.cmd));
                check_val("cmd_addr", 32'(master_maddr), 32'(e.addr));
                check_val("cmd_mid", 32'(master_mid), 32'(e.mid));
                check_val("cmd_len", 32'(master_mlength), 32'(e.len));
                check_val("cmd_accept_route", 32'(slave_scmd_accept), 32'(e.acc));
            end
        end
        if (master_mdata_valid && master_sdata_accept) begin
            beats_seen++;
            if (exp_dat_q.size() == 0) begin
                check_val("data_unexpected", 32'(master_mdata), 32'hffff_ffff);
            end else begin
                d = exp_dat_q.pop_front();
                check_val("data_word", 32'(master_mdata), 32'(d.data));
                check_val("data_last", 32'(master_mdata_last), 32'(d.last));
            end
        end
    endtask

    task automatic advance();
        @(posedge i_clk);
        #1;
        for (int p = 0; p < M; p++) begin
            if (cmd_hs[p]) void'(port_cmd_q[p].pop_front());
            if (dat_hs[p]) void'(port_dat_q[p].pop_front());
        end
        cmd_hs = '0;
        dat_hs = '0;
    endtask

    task automatic cyc();
        advance();
        settle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_cmd_q.size() + exp_dat_q.size()) != 0 && n < 200) begin
            cyc();
            n++;
        end
        check_val({tag, "_drained"}, 32'(exp_cmd_q.size() + exp_dat_q.size()), 32'd0);
        advance();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        for (int p = 0; p < M; p++) begin
            port_cmd_q[p].delete();
            port_dat_q[p].delete();
            hold[p] = 1'b0;
        end
        exp_cmd_q.delete();
        exp_dat_q.delete();
        cmd_hs = '0;
        dat_hs = '0;
        drive();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < M; p++) hold[p] = 1'b0;
        // Reset state
        drive();
        @(negedge i_clk);
        check_val("rst_pending", 32'(o_write_pending), 32'd0);
        check_val("rst_grant", 32'(o_grant), 32'd0);
        check_val("rst_mcmd_valid", 32'(master_mcmd_valid), 32'd0);
        check_val("rst_mdata_valid", 32'(master_mdata_valid), 32'd0);
        check_val("rst_sdata_accept", 32'(slave_sdata_accept), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Round-robin rotation of continuous reads
        for (int p = 0; p < M; p++) send_read(p, 16'h0100 + 16'(p));
        for (int p = 0; p < M; p++) send_read(p, 16'h0110 + 16'(p));
        for (int p = 0; p < M; p++) expect_read(p, 16'h0100 + 16'(p));
        for (int p = 0; p < M; p++) expect_read(p, 16'h0110 + 16'(p));
        settle();
        for (int i = 0; i < 6; i++) begin
            check_val("rr_grant", 32'(o_grant), 32'(1 << (i % 3)));
            if (i < 5) cyc();
        end
        drain("rot");

        // Grant lock while downstream stalls for 3 cycles
        master_scmd_accept = 1'b0;
        send_write(1, 16'h0200, 4);
        expect_write(1, 16'h0200, 4);
        settle();
        check_val("lock_grant_first", 32'(o_grant), 32'b010);
        check_val("lock_no_data", 32'(master_mdata_valid), 32'd0);
        check_val("lock_no_sdata_acc", 32'(slave_sdata_accept), 32'd0);
        send_read(0, 16'h0210);
        expect_read(0, 16'h0210);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check_val("lock_grant", 32'(o_grant), 32'b010);
            check_val("lock_addr", 32'(master_maddr), 32'h0200);
            check_val("lock_len", 32'(master_mlength), 32'd4);
        end
        advance();
        master_scmd_accept = 1'b1;
        settle();
        check_val("lock_release", 32'(o_grant), 32'b010);
        drain("lock");

        // Two writes in one cycle: data strictly in command order
        do_reset();
        beats_seen = 0;
        send_write(0, 16'h0300, 2);
        send_write(2, 16'h0310, 3);
        expect_write(0, 16'h0300, 2);
        expect_write(2, 16'h0310, 3);
        settle();
        check_val("pair_first", 32'(o_grant), 32'b001);
        for (int n = 0; n < 20 && exp_dat_q.size() != 0; n++) begin
            if (beats_seen <= 2) check_val("pair_p2_stall", 32'(slave_sdata_accept[2]), 32'd0);
            cyc();
        end
        drain("pair");

        // Full queue masks a third write but not a read
        do_reset();
        for (int p = 0; p < M; p++) hold[p] = 1'b1;
        send_write(0, 16'h0400, 1);
        send_write(1, 16'h0410, 1);
        send_write(2, 16'h0420, 1);
        expect_write(0, 16'h0400, 1);
        expect_write(1, 16'h0410, 1);
        settle();
        check_val("mask_g0", 32'(o_grant), 32'b001);
        cyc();
        check_val("mask_g1", 32'(o_grant), 32'b010);
        cyc();
        check_val("mask_pending", 32'(o_write_pending), 32'd2);
        check_val("mask_grant", 32'(o_grant), 32'b000);
        send_read(0, 16'h0430);
        expect_read(0, 16'h0430);
        expect_write(2, 16'h0420, 1);
        cyc();
        check_val("mask_read_grant", 32'(o_grant), 32'b001);
        check_val("mask_read_pending", 32'(o_write_pending), 32'd2);
        advance();
        hold[0] = 1'b0;
        settle();
        check_val("mask_still", 32'(o_grant), 32'b000);
        check_val("mask_data_valid", 32'(master_mdata_valid), 32'd1);
        cyc();
        check_val("mask_release_grant", 32'(o_grant), 32'b100);
        check_val("mask_release_pending", 32'(o_write_pending), 32'd1);
        advance();
        hold[1] = 1'b0;
        hold[2] = 1'b0;
        settle();
        drain("mask");

        // Simultaneous push and pop with pointer wrap
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send_write(i % 2, 16'h0500 + 16'(i * 16), 1);
            expect_write(i % 2, 16'h0500 + 16'(i * 16), 1);
        end
        settle();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check_val("pp_pending", 32'(o_write_pending), 32'd1);
        end
        drain("pp");

        // Asynchronous reset in the middle of a burst
        do_reset();
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        send_write(0, 16'h0600, 2);
        send_write(1, 16'h0610, 2);
        expect_write(0, 16'h0600, 2);
        expect_write(1, 16'h0610, 2);
        settle();
        cyc();
        advance();
        hold[0] = 1'b0;
        settle();
        check_val("rst_mid_pending_before", 32'(o_write_pending), 32'd2);
        i_rst = 1'b1;
        #1;
        check_val("rst_mid_pending", 32'(o_write_pending), 32'd0);
        check_val("rst_mid_mdata_valid", 32'(master_mdata_valid), 32'd0);
        do_reset();
        send_read(0, 16'h0620);
        send_read(2, 16'h0630);
        expect_read(0, 16'h0620);
        expect_read(2, 16'h0630);
        settle();
        check_val("rst_next_grant", 32'(o_grant), 32'b001);
        drain("rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
